// File: rtl/ex_div_pkg.sv
// Shared encodings for the EX-stage divider: FSM states and handshake levels.
package ex_div_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic        DivResultReady    = 1'b1;
    localparam logic        DivResultNotReady = 1'b0;
    localparam logic        DivStart          = 1'b1;
    localparam logic        DivStop           = 1'b0;
    localparam logic        RstEnable         = 1'b1;
    localparam logic [31:0] ZeroWord          = 32'h0000_0000;

endpackage

// File: rtl/ex_div_if.sv
// EX <-> divider handshake: operands and start/annul in, {remainder, quotient} and ready out.
interface ex_div_if #(
    parameter int DATA_W = 32
);
    logic                signed_div_i;
    logic [DATA_W-1:0]   opdata1_i;
    logic [DATA_W-1:0]   opdata2_i;
    logic                start_i;
    logic                annul_i;
    logic [2*DATA_W-1:0] result_o;
    logic                ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/ex_div.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle on magnitudes,
// signs restored on the final edge; divide-by-zero short-circuits to a zero result.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic    clk,
    input  logic    rst,
    ex_div_if.slave div_if
);

    div_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*DATA_W:0]   work_q;
    logic [DATA_W-1:0]   divisor_q;
    logic                signed_q;
    logic                neg1_q;
    logic                neg2_q;
    logic                ready_q;
    logic [2*DATA_W-1:0] result_q;

    logic                neg1_d;
    logic                neg2_d;
    logic [DATA_W-1:0]   abs1_d;
    logic [DATA_W-1:0]   abs2_d;
    logic [DATA_W:0]     diff_d;
    logic [DATA_W-1:0]   quot_d;
    logic [DATA_W-1:0]   rem_d;

    // NOTE: every output of this block is assigned on every path, so no latch can be inferred.
    always_comb begin
        neg1_d = div_if.signed_div_i & div_if.opdata1_i[DATA_W-1];
        neg2_d = div_if.signed_div_i & div_if.opdata2_i[DATA_W-1];
        abs1_d = neg1_d ? -div_if.opdata1_i : div_if.opdata1_i;
        abs2_d = neg2_d ? -div_if.opdata2_i : div_if.opdata2_i;
        diff_d = {1'b0, work_q[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};
        quot_d = (signed_q && (neg1_q != neg2_q)) ? -work_q[DATA_W-1:0] : work_q[DATA_W-1:0];
        rem_d  = (signed_q && neg1_q) ? -work_q[2*DATA_W:DATA_W+1] : work_q[2*DATA_W:DATA_W+1];
    end

    // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            signed_q  <= 1'b0;
            neg1_q    <= 1'b0;
            neg2_q    <= 1'b0;
            ready_q   <= DivResultNotReady;
            result_q  <= '0;
        end else begin
            case (state_q)
                DivFree: begin
                    ready_q  <= DivResultNotReady;
                    result_q <= '0;
                    if (div_if.start_i == DivStart && !div_if.annul_i) begin
                        if (div_if.opdata2_i == '0) begin
                            state_q <= DivByZero;
                        end else begin
                            state_q   <= DivOn;
                            cnt_q     <= '0;
                            signed_q  <= div_if.signed_div_i;
                            neg1_q    <= neg1_d;
                            neg2_q    <= neg2_d;
                            divisor_q <= abs2_d;
                            work_q    <= {{DATA_W{1'b0}}, abs1_d, 1'b0};
                        end
                    end
                end
                DivByZero: begin
                    if (div_if.annul_i) begin
                        state_q <= DivFree;
                    end else begin
                        state_q  <= DivEnd;
                        ready_q  <= DivResultReady;
                        result_q <= '0;
                    end
                end
                DivOn: begin
                    if (div_if.annul_i) begin
                        state_q <= DivFree;
                    end else if (cnt_q == CNT_W'(DATA_W)) begin
                        state_q  <= DivEnd;
                        ready_q  <= DivResultReady;
                        result_q <= {rem_d, quot_d};
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        // Borrow means the divisor did not fit: keep the partial remainder.
                        if (diff_d[DATA_W]) begin
                            work_q <= {work_q[2*DATA_W-1:0], 1'b0};
                        end else begin
                            work_q <= {diff_d[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
                        end
                    end
                end
                DivEnd: begin
                    if (div_if.start_i == DivStop) begin
                        state_q  <= DivFree;
                        ready_q  <= DivResultNotReady;
                        result_q <= '0;
                    end
                end
                default: state_q <= DivFree;
            endcase
        end
    end

    assign div_if.ready_o  = ready_q;
    assign div_if.result_o = result_q;

endmodule
